// File: rtl/image_link_ctrl_pkg.sv
// Shared types and constants for the image link controller (FSM states, header layout, error codes).
// Optional checksum trailer is enabled by defining IMAGE_LINK_CKSUM_EN.
`timescale 1ns/1ps
package image_link_ctrl_pkg;

  typedef enum logic [3:0] {
    LS_IDLE,
    LS_HDR_CFG,
    LS_HDR_W0,
    LS_HDR_W1,
    LS_HDR_H0,
    LS_HDR_H1,
    LS_STREAM,
    LS_DRAIN,
    LS_TRAILER
  } link_state_t;

  localparam logic [7:0] LINK_SYNC_BYTE = 8'hA5;

  localparam logic [1:0] LINK_ERR_NONE     = 2'd0;
  localparam logic [1:0] LINK_ERR_BAD_HDR  = 2'd1;
  localparam logic [1:0] LINK_ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] LINK_ERR_OVERFLOW = 2'd3;

  // Byte offsets of the header fields within the RX stream
  localparam int LINK_HDR_OFF_SYNC = 0;
  localparam int LINK_HDR_OFF_CFG  = 1;
  localparam int LINK_HDR_OFF_W_LO = 2;
  localparam int LINK_HDR_OFF_W_HI = 3;
  localparam int LINK_HDR_OFF_H_LO = 4;
  localparam int LINK_HDR_OFF_H_HI = 5;

  function automatic int ksel_w(input int n_kernels);
    return (n_kernels > 2) ? $clog2(n_kernels) : 1;
  endfunction

endpackage

// File: rtl/image_link_ctrl_if.sv
// Byte/pixel link bundle between UART, Canny pipeline and the link controller.
// slave = controller side, master = surrounding chip / testbench side.
`timescale 1ns/1ps
interface image_link_if
  import image_link_ctrl_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int N_KERNELS = 2
);
  localparam int KSEL_W = ksel_w(N_KERNELS);

  logic [PIX_W-1:0]  rx_data;
  logic              rx_valid;
  logic [PIX_W-1:0]  pix_out;
  logic              pix_out_valid;
  logic [PIX_W-1:0]  pix_in;
  logic              pix_in_valid;
  logic [PIX_W-1:0]  tx_data;
  logic              tx_wr;
  logic              tx_full;
  logic [KSEL_W-1:0] kernel_select;
  logic [1:0]        fill_select;
  logic              busy;
  logic              frame_done;
  logic [1:0]        err_code;

  modport slave (
    input  rx_data, rx_valid, pix_in, pix_in_valid, tx_full,
    output pix_out, pix_out_valid, tx_data, tx_wr,
           kernel_select, fill_select, busy, frame_done, err_code
  );

  modport master (
    output rx_data, rx_valid, pix_in, pix_in_valid, tx_full,
    input  pix_out, pix_out_valid, tx_data, tx_wr,
           kernel_select, fill_select, busy, frame_done, err_code
  );

endinterface

// File: rtl/image_link_ctrl_obuf.sv
// link_obuf: synchronous FIFO buffering pipeline output against TX back-pressure.
// Push on a full FIFO is accepted only when a pop happens in the same cycle.
`timescale 1ns/1ps
module link_obuf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = pop && !empty;
  assign do_wr = push && (!full || do_rd);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstN || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/image_link_ctrl.sv
// Frame-level link controller: parses the in-band header, forwards W*H pixels, buffers results for TX.
// Define IMAGE_LINK_CKSUM_EN to append an XOR checksum trailer byte to every completed frame.
`timescale 1ns/1ps
module image_link_ctrl
  import image_link_ctrl_pkg::*;
#(
  parameter int PIX_W       = 8,
  parameter int MAX_W       = 640,
  parameter int MAX_H       = 480,
  parameter int N_KERNELS   = 2,
  parameter int OBUF_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rstN,
  image_link_if.slave link
);
  localparam int KSEL_W = ksel_w(N_KERNELS);
  localparam int CNT_W  = $clog2(MAX_W*MAX_H+1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC+1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  link_state_t      state;
  logic [7:0]       cfg_q, w_lo_q, w_hi_q, h_lo_q;
  logic [CNT_W-1:0] wh_q, in_cnt, out_cnt, wh_calc;
  logic [TO_W-1:0]  to_cnt;
  logic [15:0]      hdr_w, hdr_h;
  logic             hdr_bad;
  logic             out_phase, activity, timeout_hit, overflow;
  logic             ob_push, ob_pop, ob_full, ob_empty;
  logic [PIX_W-1:0] ob_dout;

  assign hdr_w   = {w_hi_q, w_lo_q};
  assign hdr_h   = {link.rx_data, h_lo_q};
  assign hdr_bad = (hdr_w == '0) || (hdr_h == '0) ||
                   (32'(hdr_w) > MAX_W) || (32'(hdr_h) > MAX_H) ||
                   (32'(cfg_q[7:2]) >= N_KERNELS);
  assign wh_calc = CNT_W'(hdr_w) * CNT_W'(hdr_h);

  assign out_phase   = (state == LS_STREAM) || (state == LS_DRAIN);
  assign activity    = link.rx_valid || link.pix_in_valid;
  assign timeout_hit = out_phase && !activity && (to_cnt == TO_W'(TIMEOUT_CYC-1));

  // A pop frees a slot in the same cycle, so push-on-full with pop is not an overflow
  assign ob_pop   = !ob_empty && !link.tx_full;
  assign ob_push  = out_phase && link.pix_in_valid && (!ob_full || ob_pop);
  assign overflow = out_phase && link.pix_in_valid && ob_full && !ob_pop;

`ifdef IMAGE_LINK_CKSUM_EN
  logic [7:0] cksum;
  logic       trailer_wr;
  assign trailer_wr   = (state == LS_TRAILER) && !link.tx_full;
  assign link.tx_wr   = ob_pop || trailer_wr;
  assign link.tx_data = trailer_wr ? cksum : (ob_empty ? '0 : ob_dout);
`else
  assign link.tx_wr   = ob_pop;
  assign link.tx_data = ob_empty ? '0 : ob_dout;
`endif

  link_obuf #(
    .WIDTH (PIX_W),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk   (clk),
    .rstN  (rstN),
    .push  (ob_push),
    .pop   (ob_pop),
    .flush (timeout_hit),
    .din   (link.pix_in),
    .dout  (ob_dout),
    .full  (ob_full),
    .empty (ob_empty)
  );

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state              <= LS_IDLE;
      cfg_q              <= '0;
      w_lo_q             <= '0;
      w_hi_q             <= '0;
      h_lo_q             <= '0;
      wh_q               <= '0;
      in_cnt             <= '0;
      out_cnt            <= '0;
      to_cnt             <= '0;
      link.pix_out       <= '0;
      link.pix_out_valid <= 1'b0;
      link.kernel_select <= '0;
      link.fill_select   <= '0;
      link.busy          <= 1'b0;
      link.frame_done    <= 1'b0;
      link.err_code      <= LINK_ERR_NONE;
`ifdef IMAGE_LINK_CKSUM_EN
      cksum              <= '0;
`endif
    end else begin
      link.pix_out_valid <= 1'b0;
      link.frame_done    <= 1'b0;

      if (out_phase && link.pix_in_valid) begin
        if (out_cnt != CNT_MAX) out_cnt <= out_cnt + CNT_W'(1);
        if (overflow) link.err_code <= LINK_ERR_OVERFLOW;
      end

      if (out_phase) to_cnt <= activity ? '0 : to_cnt + TO_W'(1);
      else           to_cnt <= '0;

`ifdef IMAGE_LINK_CKSUM_EN
      if (out_phase && ob_pop) cksum <= cksum ^ 8'(ob_dout);
`endif

      case (state)
        LS_IDLE: begin
          if (link.rx_valid && (link.rx_data == LINK_SYNC_BYTE)) begin
            state         <= LS_HDR_CFG;
            link.err_code <= LINK_ERR_NONE;
            link.busy     <= 1'b1;
`ifdef IMAGE_LINK_CKSUM_EN
            cksum         <= '0;
`endif
          end
        end
        LS_HDR_CFG: if (link.rx_valid) begin cfg_q  <= link.rx_data; state <= LS_HDR_W0; end
        LS_HDR_W0:  if (link.rx_valid) begin w_lo_q <= link.rx_data; state <= LS_HDR_W1; end
        LS_HDR_W1:  if (link.rx_valid) begin w_hi_q <= link.rx_data; state <= LS_HDR_H0; end
        LS_HDR_H0:  if (link.rx_valid) begin h_lo_q <= link.rx_data; state <= LS_HDR_H1; end
        LS_HDR_H1: begin
          if (link.rx_valid) begin
            if (hdr_bad) begin
              link.err_code <= LINK_ERR_BAD_HDR;
              link.busy     <= 1'b0;
              state         <= LS_IDLE;
            end else begin
              link.kernel_select <= cfg_q[KSEL_W+1:2];
              link.fill_select   <= cfg_q[1:0];
              wh_q               <= wh_calc;
              in_cnt             <= '0;
              out_cnt            <= '0;
              state              <= LS_STREAM;
            end
          end
        end
        LS_STREAM: begin
          if (link.rx_valid) begin
            link.pix_out       <= link.rx_data;
            link.pix_out_valid <= 1'b1;
            in_cnt             <= in_cnt + CNT_W'(1);
            if ((in_cnt + CNT_W'(1)) == wh_q) state <= LS_DRAIN;
          end
        end
        LS_DRAIN: begin
          if ((out_cnt == wh_q) && ob_empty && !link.pix_in_valid) begin
`ifdef IMAGE_LINK_CKSUM_EN
            state           <= LS_TRAILER;
`else
            state           <= LS_IDLE;
            link.busy       <= 1'b0;
            link.frame_done <= 1'b1;
`endif
          end
        end
        LS_TRAILER: begin
`ifdef IMAGE_LINK_CKSUM_EN
          if (!link.tx_full) begin
            state           <= LS_IDLE;
            link.busy       <= 1'b0;
            link.frame_done <= 1'b1;
          end
`else
          state <= LS_IDLE;
`endif
        end
        default: state <= LS_IDLE;
      endcase

      // Timeout abandons the frame regardless of where it stood
      if (timeout_hit) begin
        state           <= LS_IDLE;
        link.busy       <= 1'b0;
        link.frame_done <= 1'b0;
        link.err_code   <= LINK_ERR_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_image_link_ctrl.sv
// Directed, table-driven bench for image_link_ctrl with a 3-cycle echo model of the pipeline.
// Covers header validation, frame forwarding, overflow, timeout, mid-frame reset and (IMAGE_LINK_CKSUM_EN) the trailer.
`timescale 1ns/1ps
module tb_image_link_ctrl;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  image_link_if #(.PIX_W(8), .N_KERNELS(2)) bus ();

  image_link_ctrl #(
    .PIX_W       (8),
    .MAX_W       (640),
    .MAX_H       (480),
    .N_KERNELS   (2),
    .OBUF_DEPTH  (16),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .link (bus)
  );

  // Pipeline model: pure echo with three register stages
  logic [2:0] e_v = '0;
  logic [7:0] e_d [3];
  always @(posedge clk) begin
    e_v    <= {e_v[1:0], bus.pix_out_valid};
    e_d[0] <= bus.pix_out;
    e_d[1] <= e_d[0];
    e_d[2] <= e_d[1];
  end
  assign bus.pix_in       = e_d[2];
  assign bus.pix_in_valid = e_v[2];

  logic [7:0] tx_q[$];
  int fd_cnt = 0;
  int pov_cnt = 0;
  int wr_full_viol = 0;
  always @(negedge clk) begin
    if (bus.tx_wr) tx_q.push_back(bus.tx_data);
    if (bus.tx_wr && bus.tx_full) wr_full_viol++;
    if (bus.frame_done) fd_cnt++;
    if (bus.pix_out_valid) pov_cnt++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_header(input logic [7:0] cfg, input logic [15:0] w, input logic [15:0] h);
    send_byte(8'hA5);
    send_byte(cfg);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(h[7:0]);
    send_byte(h[15:8]);
  endtask

  task automatic wait_done(input string name, input int fd0, input int budget);
    int n;
    n = 0;
    while (fd_cnt == fd0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (fd_cnt == fd0) check({name, "_done_timeout"}, 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // Expects tx bytes base..base+n-1, plus the XOR trailer when the checksum is built in
  task automatic check_tx(input string name, input logic [7:0] base, input int n);
    int errs;
    int exp_n;
    logic [7:0] x;
    logic [7:0] e;
    errs  = 0;
    x     = 8'h00;
    exp_n = n;
`ifdef IMAGE_LINK_CKSUM_EN
    exp_n = n + 1;
`endif
    check({name, "_tx_count"}, tx_q.size(), exp_n);
    for (int i = 0; i < n; i++) begin
      e = base + 8'(i);
      x = x ^ e;
      if (i < tx_q.size() && tx_q[i] !== e) errs++;
    end
`ifdef IMAGE_LINK_CKSUM_EN
    if (tx_q.size() > n && tx_q[n] !== x) errs++;
`endif
    check({name, "_tx_bytes"}, errs, 0);
  endtask

  typedef struct packed {
    logic [7:0]  cfg;
    logic [15:0] w;
    logic [15:0] h;
    logic [1:0]  exp_err;
    logic [0:0]  exp_k;
    logic [1:0]  exp_f;
    logic [7:0]  base;
  } vec_t;

  task automatic run_frame(input string tag, input vec_t v);
    int fd0;
    int pov0;
    tx_q.delete();
    fd0  = fd_cnt;
    pov0 = pov_cnt;
    send_header(v.cfg, v.w, v.h);
    @(negedge clk);
    check({tag, "_err_hdr"}, bus.err_code, v.exp_err);
    check({tag, "_kernel"}, bus.kernel_select, v.exp_k);
    check({tag, "_fill"}, bus.fill_select, v.exp_f);
    if (v.exp_err == 2'd0) begin
      check({tag, "_busy"}, bus.busy, 1);
      for (int i = 0; i < int'(v.w) * int'(v.h); i++) send_byte(v.base + 8'(i));
      wait_done(tag, fd0, 400);
      check({tag, "_pix_out_cnt"}, pov_cnt - pov0, int'(v.w) * int'(v.h));
      check({tag, "_frame_done_cnt"}, fd_cnt - fd0, 1);
      check({tag, "_busy_end"}, bus.busy, 0);
      check({tag, "_err_end"}, bus.err_code, 0);
      check_tx(tag, v.base, int'(v.w) * int'(v.h));
    end else begin
      repeat (4) @(negedge clk);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_no_pix_out"}, pov_cnt - pov0, 0);
      check({tag, "_no_done"}, fd_cnt - fd0, 0);
    end
  endtask

  vec_t vt[8];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int fd0;
    int n;

    vt[0] = '{8'h05, 16'd4,     16'd3,   2'd0, 1'b1, 2'd1, 8'h00};
    vt[1] = '{8'h05, 16'h0281,  16'd1,   2'd1, 1'b1, 2'd1, 8'h00};
    vt[2] = '{8'h02, 16'd2,     16'd2,   2'd0, 1'b0, 2'd2, 8'h80};
    vt[3] = '{8'h05, 16'd4,     16'd0,   2'd1, 1'b0, 2'd2, 8'h00};
    vt[4] = '{8'h09, 16'd1,     16'd1,   2'd1, 1'b0, 2'd2, 8'h00};
    vt[5] = '{8'h06, 16'd3,     16'd481, 2'd1, 1'b0, 2'd2, 8'h00};
    vt[6] = '{8'h07, 16'd1,     16'd1,   2'd0, 1'b1, 2'd3, 8'hC3};
    vt[7] = '{8'h00, 16'd0,     16'd5,   2'd1, 1'b1, 2'd3, 8'h00};

    rstN         = 1'b0;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.tx_full  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pix_out_valid", bus.pix_out_valid, 0);
    check("rst_tx_wr", bus.tx_wr, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_pix_out", bus.pix_out, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_kernel", bus.kernel_select, 0);
    check("rst_fill", bus.fill_select, 0);
    check("rst_err", bus.err_code, 0);
    @(posedge clk); #1;
    rstN = 1'b1;

    // Junk before sync must be ignored
    send_byte(8'h11);
    send_byte(8'h5A);
    @(negedge clk);
    check("idle_junk_busy", bus.busy, 0);

    for (int i = 0; i < 8; i++) run_frame($sformatf("vec%0d", i), vt[i]);

    // Output overflow: 5x4 frame while TX is held full
    tx_q.delete();
    fd0 = fd_cnt;
    @(posedge clk); #1;
    bus.tx_full = 1'b1;
    send_header(8'h05, 16'd5, 16'd4);
    for (int i = 0; i < 20; i++) send_byte(8'h20 + 8'(i));
    repeat (10) @(posedge clk);
    check("ovf_held_no_tx", tx_q.size(), 0);
    check("ovf_err", bus.err_code, 3);
    #1;
    bus.tx_full = 1'b0;
    wait_done("ovf", fd0, 300);
    check("ovf_frame_done", fd_cnt - fd0, 1);
    check("ovf_err_sticky", bus.err_code, 3);
    check_tx("ovf", 8'h20, 16);

    // Timeout: 4x4 frame abandoned after 5 pixels
    tx_q.delete();
    fd0 = fd_cnt;
    send_header(8'h05, 16'd4, 16'd4);
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i));
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.err_code == 2'd2) break;
    end
    check("timeout_err", bus.err_code, 2);
    check("timeout_latency_in_range", int'(n >= 100 && n <= 106), 1);
    check("timeout_busy", bus.busy, 0);
    check("timeout_no_done", fd_cnt - fd0, 0);
    check("timeout_tx_count", tx_q.size(), 5);

    // Reset pulse in the middle of a streaming frame
    send_header(8'h05, 16'd4, 16'd4);
    for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i));
    @(posedge clk); #1;
    rstN = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    check("mrst_busy", bus.busy, 0);
    check("mrst_kernel", bus.kernel_select, 0);
    check("mrst_fill", bus.fill_select, 0);
    check("mrst_err", bus.err_code, 0);
    check("mrst_pix_out", bus.pix_out, 0);
    check("mrst_pix_out_valid", bus.pix_out_valid, 0);
    check("mrst_tx_wr", bus.tx_wr, 0);
    repeat (6) @(negedge clk);
    run_frame("post_rst", vt[0]);

`ifdef IMAGE_LINK_CKSUM_EN
    tx_q.delete();
    fd0 = fd_cnt;
    send_header(8'h05, 16'd2, 16'd1);
    send_byte(8'h3C);
    send_byte(8'h0F);
    wait_done("cksum", fd0, 200);
    check("cksum_count", tx_q.size(), 3);
    if (tx_q.size() == 3) begin
      check("cksum_b0", tx_q[0], 8'h3C);
      check("cksum_b1", tx_q[1], 8'h0F);
      check("cksum_b2", tx_q[2], 8'h33);
    end
    check("cksum_done", fd_cnt - fd0, 1);
`endif

    check("tx_wr_while_full", wr_full_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
